mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch requester and the data-access requester of the RISC-V core. The data requester is driven by the control unit's MEM_READ/MEM_WRITE. Each access is sequenced through a small FSM that latches the winner's address and write data, holds the port until the memory drops busywait, and returns read data. Each requester gets a BUSYWAIT stall signal, which the pipeline uses to freeze.

## Interface
- ADDR_WIDTH, 32, address width of both requesters and the port
- DATA_WIDTH, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits (used only with the starvation guard)
- CLK  input  1  clock; all registers update on the rising edge
- RESET  input  1  asynchronous, active-high reset
- I_READ / I_ADDR  input  1 / ADDR_WIDTH  fetch request and fetch address
- I_READDATA  output  DATA_WIDTH  registered fetch data
- I_BUSYWAIT  output  1  fetch stall
- D_READ / D_WRITE  input  1 / 1  data read and write requests
- D_ADDR / D_WRITEDATA  input  ADDR_WIDTH / DATA_WIDTH  data address and store data
- D_READDATA  output  DATA_WIDTH  registered load data
- D_BUSYWAIT  output  1  data stall
- PORT_READ / PORT_WRITE  output  1 / 1  memory strobes
- PORT_ADDR / PORT_WRITEDATA  output  ADDR_WIDTH / DATA_WIDTH  latched address and write data
- PORT_READDATA / PORT_BUSYWAIT  input  DATA_WIDTH / 1  memory response

## Operation
- **States:** IDLE, GRANT_I, GRANT_D, RESP.
- **Request definitions:** I_REQ = I_READ. D_REQ = D_READ | D_WRITE.
- **IDLE:**
  - If D_REQ, go to GRANT_D.
  - Else if I_REQ, go to GRANT_I.
  - On transition, latch the winner's address, write data and op. Latch write if D_WRITE, else read.
  - D_READ and D_WRITE both high is treated as a write.
- **GRANT_x:**
  - PORT_* is driven from the latched registers.
  - Completion is the first edge with PORT_BUSYWAIT = 0.
  - On completion, capture PORT_READDATA into I_READDATA or D_READDATA (reads only; writes leave D_READDATA unchanged).
  - Set the done flag for the owner, then go to RESP.
- **RESP:**
  - Port strobes are 0.
  - done_x is high for exactly this cycle.
  - Always go to IDLE; no arbitration happens in RESP, so a just-served request held high is not re-granted as stale.
- **Stall outputs:**
  - X_BUSYWAIT = X_REQ & ~done_x, combinational.
  - A requester sees BUSYWAIT low only in its RESP cycle.
- **Parallel requests:** inputs of the non-owner are ignored while the other request is in flight.

## Timing
- **Reset values:**
  - State IDLE; PORT_READ, PORT_WRITE, PORT_ADDR, PORT_WRITEDATA all 0.
  - I_READDATA and D_READDATA are 0.
  - Done flags 0, so X_BUSYWAIT = X_REQ during and after reset.
- **Latency:**
  - Request seen in IDLE at cycle 0, port strobe in cycles 1..1+W (W = memory wait cycles), RESP in cycle 2+W.
  - Minimum is 2 cycles.
- **Back-to-back:** RESP then IDLE gives 1 idle cycle between accesses, for a throughput of one access per 3+W cycles.
- **Strobe stability:** PORT_ADDR and PORT_WRITEDATA are stable for the whole grant, even if requester inputs change.
- **Reset mid-access:** return to IDLE immediately, drop strobes, discard the access and leave no done flag.
- **Counter wrap:** the streak counter saturates at MAX_D_STREAK and never wraps.

## Configuration
- **ARB_STARVE_GUARD_EN defined:**
  - A counter increments on each GRANT_D entry taken while I_REQ is high.
  - When the count equals MAX_D_STREAK, IDLE grants I even if D_REQ is high.
  - The counter clears on GRANT_I entry, or when entering GRANT_D with I_REQ low.
- **Not defined:** data always has strict priority; no counter logic is present.

## Structure
- **Package mem_arb_pkg:** state enum (IDLE, GRANT_I, GRANT_D, RESP), owner encoding (OWN_I, OWN_D), and the op encoding (OP_RD, OP_WR).
- **Sub-module mem_arb_streak_ctr:** saturating counter with inc/clr/at_max outputs. It is instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- **Zero-wait fetch:**
  - Stimulus: I_READ=1, I_ADDR=0x40, PORT_BUSYWAIT=0, PORT_READDATA=0x00500093.
  - Response: PORT_READ high in cycle 1. I_BUSYWAIT low in cycle 2, with I_READDATA=0x00500093.
- **Collision:**
  - Stimulus: I_READ and D_WRITE both high, D_ADDR=0x100, D_WRITEDATA=0xDEADBEEF, memory W=3.
  - Response: data is served first. PORT_WRITE high in cycles 1–4. D_BUSYWAIT low in cycle 5. Fetch is granted at cycle 7.
- **Input change mid-access:**
  - Stimulus: D_ADDR changes during the grant.
  - Response: PORT_ADDR holds the latched value.
- **Starvation guard (ARB_STARVE_GUARD_EN, MAX_D_STREAK=2):**
  - Stimulus: D_READ and I_READ held continuously high.
  - Response: grant order D, D, I, D, D, I.
- **Reset mid-access:**
  - Stimulus: RESET pulse during GRANT_D with W=5.
  - Response: strobes are 0 within the same cycle, D_READDATA=0, state IDLE. Access re-issues after reset releases.
- **Read and write both high:**
  - Stimulus: D_READ=D_WRITE=1.
  - Response: PORT_WRITE=1, PORT_READ=0, D_READDATA unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, port owner and op encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  function automatic logic is_grant(input state_t s);
    return (s == GRANT_I) || (s == GRANT_D);
  endfunction

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module mem_arb_streak_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] count_r;

  // Count up to MAX and stick there; clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= CW'(0);
    end else if (clr) begin
      count_r <= CW'(0);
    end else if (inc && !at_max) begin
      count_r <= count_r + CW'(1);
    end
  end

  assign at_max = (count_r == CW'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and data access.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  I_READ,
  input  logic [ADDR_WIDTH-1:0] I_ADDR,
  output logic [DATA_WIDTH-1:0] I_READDATA,
  output logic                  I_BUSYWAIT,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_ADDR,
  input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
  output logic [DATA_WIDTH-1:0] D_READDATA,
  output logic                  D_BUSYWAIT,
  output logic                  PORT_READ,
  output logic                  PORT_WRITE,
  output logic [ADDR_WIDTH-1:0] PORT_ADDR,
  output logic [DATA_WIDTH-1:0] PORT_WRITEDATA,
  input  logic [DATA_WIDTH-1:0] PORT_READDATA,
  input  logic                  PORT_BUSYWAIT
);

  state_t                state_r, state_nxt_s;
  owner_t                owner_r;
  op_t                   op_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r, i_rdata_r, d_rdata_r;
  logic                  done_i_r, done_d_r;
  logic                  i_req_s, d_req_s, pick_d_s, complete_s, streak_at_max_s;
  logic                  port_read_s, port_write_s;

  assign i_req_s    = I_READ;
  assign d_req_s    = D_READ | D_WRITE;
  assign pick_d_s   = d_req_s & ~(i_req_s & streak_at_max_s);
  assign complete_s = is_grant(state_r) & ~PORT_BUSYWAIT;

`ifdef ARB_STARVE_GUARD_EN
  logic enter_d_s, enter_i_s;
  assign enter_d_s = (state_r == IDLE) & pick_d_s;
  assign enter_i_s = (state_r == IDLE) & ~pick_d_s & i_req_s;

  mem_arb_streak_ctr #(.MAX(MAX_D_STREAK)) u_streak (
    .clk    (CLK),
    .rst    (RESET),
    .inc    (enter_d_s & i_req_s),
    .clr    (enter_i_s | (enter_d_s & ~i_req_s)),
    .at_max (streak_at_max_s)
  );
`else
  // Strict data priority: the streak limit can never be reached.
  assign streak_at_max_s = (MAX_D_STREAK < 32'sd0);
`endif

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next state; RESP never arbitrates so a held request is not re-granted stale.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_d_s)     state_nxt_s = GRANT_D;
        else if (i_req_s) state_nxt_s = GRANT_I;
        else              state_nxt_s = IDLE;
      end
      GRANT_I, GRANT_D: begin
        if (!PORT_BUSYWAIT) state_nxt_s = RESP;
        else                state_nxt_s = state_r;
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Latch the winner's request so the port stays stable for the whole grant.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner_r <= OWN_I;
      op_r    <= OP_RD;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
    end else if ((state_r == IDLE) && pick_d_s) begin
      owner_r <= OWN_D;
      op_r    <= D_WRITE ? OP_WR : OP_RD;
      addr_r  <= D_ADDR;
      wdata_r <= D_WRITEDATA;
    end else if ((state_r == IDLE) && i_req_s) begin
      owner_r <= OWN_I;
      op_r    <= OP_RD;
      addr_r  <= I_ADDR;
      wdata_r <= {DATA_WIDTH{1'b0}};
    end
  end

  // Capture read data and raise the owner's one-cycle done flag on completion.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      i_rdata_r <= {DATA_WIDTH{1'b0}};
      d_rdata_r <= {DATA_WIDTH{1'b0}};
      done_i_r  <= 1'b0;
      done_d_r  <= 1'b0;
    end else begin
      done_i_r <= complete_s & (owner_r == OWN_I);
      done_d_r <= complete_s & (owner_r == OWN_D);
      if (complete_s && (op_r == OP_RD) && (owner_r == OWN_I)) i_rdata_r <= PORT_READDATA;
      if (complete_s && (op_r == OP_RD) && (owner_r == OWN_D)) d_rdata_r <= PORT_READDATA;
    end
  end

  // Port strobes decoded from the registered state and latched op.
  always_comb begin
    port_read_s  = 1'b0;
    port_write_s = 1'b0;
    if (is_grant(state_r)) begin
      port_read_s  = (op_r == OP_RD);
      port_write_s = (op_r == OP_WR);
    end else begin
      port_read_s  = 1'b0;
      port_write_s = 1'b0;
    end
  end

  assign PORT_READ      = port_read_s;
  assign PORT_WRITE     = port_write_s;
  assign PORT_ADDR      = addr_r;
  assign PORT_WRITEDATA = wdata_r;
  assign I_READDATA     = i_rdata_r;
  assign D_READDATA     = d_rdata_r;
  assign I_BUSYWAIT     = i_req_s & ~done_i_r;
  assign D_BUSYWAIT     = d_req_s & ~done_d_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, randomized transactions, corner sequences.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        I_READ, D_READ, D_WRITE;
  logic [31:0] I_ADDR, D_ADDR, D_WRITEDATA;
  logic [31:0] I_READDATA, D_READDATA;
  logic        I_BUSYWAIT, D_BUSYWAIT;
  logic        PORT_READ, PORT_WRITE, PORT_BUSYWAIT;
  logic [31:0] PORT_ADDR, PORT_WRITEDATA, PORT_READDATA;

  int          checks = 0;
  int          errors = 0;
  int          mem_w  = 0;
  int          mem_cnt;
  logic [31:0] exp_i_rdata, exp_d_rdata;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_D_STREAK(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDR(I_ADDR), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .PORT_READ(PORT_READ), .PORT_WRITE(PORT_WRITE), .PORT_ADDR(PORT_ADDR),
    .PORT_WRITEDATA(PORT_WRITEDATA), .PORT_READDATA(PORT_READDATA), .PORT_BUSYWAIT(PORT_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory: busy for the first mem_w cycles of any strobe.
  always @(posedge CLK or posedge RESET) begin
    if (RESET)                       mem_cnt <= 0;
    else if (PORT_READ || PORT_WRITE) mem_cnt <= mem_cnt + 1;
    else                             mem_cnt <= 0;
  end
  assign PORT_BUSYWAIT = (PORT_READ || PORT_WRITE) && (mem_cnt < mem_w);

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One access: called at the negedge of the IDLE cycle that arbitrates it;
  // returns at the negedge of the following IDLE cycle.
  task automatic serve(input bit own_d, input bit is_wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int w, input bit perturb, input bit drop);
    mem_w = w;
    PORT_READDATA = rdata;
    for (int k = 1; k <= 1 + w; k++) begin
      @(negedge CLK);
      chk1("grant_port_read", PORT_READ, !is_wr);
      chk1("grant_port_write", PORT_WRITE, is_wr);
      chk32("grant_port_addr", PORT_ADDR, addr);
      if (own_d) chk32("grant_port_wdata", PORT_WRITEDATA, wdata);
      chk1("grant_i_busywait", I_BUSYWAIT, I_READ);
      chk1("grant_d_busywait", D_BUSYWAIT, D_READ | D_WRITE);
      if (perturb) begin
        if (own_d) begin
          D_ADDR = $urandom;
          D_WRITEDATA = $urandom;
        end else begin
          I_ADDR = $urandom;
        end
      end
    end
    @(negedge CLK);
    chk1("resp_port_read", PORT_READ, 1'b0);
    chk1("resp_port_write", PORT_WRITE, 1'b0);
    if (!is_wr) begin
      if (own_d) exp_d_rdata = rdata;
      else       exp_i_rdata = rdata;
    end
    chk1("resp_i_busywait", I_BUSYWAIT, own_d ? I_READ : 1'b0);
    chk1("resp_d_busywait", D_BUSYWAIT, own_d ? 1'b0 : (D_READ | D_WRITE));
    chk32("resp_i_readdata", I_READDATA, exp_i_rdata);
    chk32("resp_d_readdata", D_READDATA, exp_d_rdata);
    if (drop) begin
      if (own_d) begin
        D_READ = 1'b0;
        D_WRITE = 1'b0;
      end else begin
        I_READ = 1'b0;
      end
    end
    @(negedge CLK);
    chk1("idle_port_read", PORT_READ, 1'b0);
    chk1("idle_port_write", PORT_WRITE, 1'b0);
    chk1("idle_i_busywait", I_BUSYWAIT, I_READ);
    chk1("idle_d_busywait", D_BUSYWAIT, D_READ | D_WRITE);
  endtask

  typedef struct {
    bit          i_rd, d_rd, d_wr;
    int          w;
    logic [31:0] i_addr, d_addr, d_wdata, rdata_d, rdata_i;
    bit          exp_d_first, exp_wr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 0, 32'h40, 32'h0, 32'h0, 32'h0, 32'h00500093, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 2, 32'h44, 32'h300, 32'h0, 32'hCAFEF00D, 32'h00000013, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 3, 32'h48, 32'h100, 32'hDEADBEEF, 32'h11111111, 32'h00A00113, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1, 32'h0, 32'h200, 32'h12345678, 32'h22222222, 32'h0, 1'b1, 1'b1};

    RESET = 1'b1;
    I_READ = 1'b1; D_READ = 1'b0; D_WRITE = 1'b0;
    I_ADDR = 32'h0; D_ADDR = 32'h0; D_WRITEDATA = 32'h0; PORT_READDATA = 32'h0;
    exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
    @(negedge CLK);
    @(negedge CLK);
    chk1("rst_port_read", PORT_READ, 1'b0);
    chk1("rst_port_write", PORT_WRITE, 1'b0);
    chk32("rst_port_addr", PORT_ADDR, 32'h0);
    chk32("rst_port_wdata", PORT_WRITEDATA, 32'h0);
    chk32("rst_i_readdata", I_READDATA, 32'h0);
    chk32("rst_d_readdata", D_READDATA, 32'h0);
    chk1("rst_i_busywait", I_BUSYWAIT, 1'b1);
    chk1("rst_d_busywait", D_BUSYWAIT, 1'b0);
    I_READ = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);

    // Directed table from the test plan.
    for (int v = 0; v < 4; v++) begin
      I_READ = vecs[v].i_rd; I_ADDR = vecs[v].i_addr;
      D_READ = vecs[v].d_rd; D_WRITE = vecs[v].d_wr;
      D_ADDR = vecs[v].d_addr; D_WRITEDATA = vecs[v].d_wdata;
      if (vecs[v].exp_d_first) begin
        serve(1'b1, vecs[v].exp_wr, vecs[v].d_addr, vecs[v].d_wdata, vecs[v].rdata_d,
              vecs[v].w, 1'b1, 1'b1);
        if (vecs[v].i_rd)
          serve(1'b0, 1'b0, vecs[v].i_addr, 32'h0, vecs[v].rdata_i, vecs[v].w, 1'b0, 1'b1);
      end else begin
        serve(1'b0, vecs[v].exp_wr, vecs[v].i_addr, 32'h0, vecs[v].rdata_i, vecs[v].w, 1'b1, 1'b1);
      end
    end

    // Randomized transactions: data wins whenever requested, fetch follows.
    for (int n = 0; n < 30; n++) begin
      int          dop, w;
      bit          irq;
      logic [31:0] ia, da, dw;
      irq = 1'($urandom_range(0, 1));
      dop = $urandom_range(0, 3);
      w   = $urandom_range(0, 3);
      ia = $urandom; da = $urandom; dw = $urandom;
      I_READ = irq; I_ADDR = ia;
      D_READ = (dop == 1) || (dop == 3);
      D_WRITE = (dop >= 2);
      D_ADDR = da; D_WRITEDATA = dw;
      if (dop != 0) serve(1'b1, dop >= 2, da, dw, $urandom, w, 1'b1, 1'b1);
      if (irq) serve(1'b0, 1'b0, ia, 32'h0, $urandom, w, 1'b1, 1'b1);
      if (!irq && dop == 0) begin
        @(negedge CLK);
        chk1("rand_idle_read", PORT_READ, 1'b0);
        chk1("rand_idle_write", PORT_WRITE, 1'b0);
        chk1("rand_idle_i_bw", I_BUSYWAIT, 1'b0);
        chk1("rand_idle_d_bw", D_BUSYWAIT, 1'b0);
      end
    end

    // Reset in the middle of a long data read.
    mem_w = 5; PORT_READDATA = 32'h00000077;
    D_READ = 1'b1; D_ADDR = 32'h500; D_WRITEDATA = 32'h0;
    @(negedge CLK);
    @(negedge CLK);
    chk1("pre_rst_read", PORT_READ, 1'b1);
    RESET = 1'b1;
    #1;
    chk1("midrst_read", PORT_READ, 1'b0);
    chk1("midrst_write", PORT_WRITE, 1'b0);
    chk32("midrst_d_readdata", D_READDATA, 32'h0);
    chk1("midrst_d_busywait", D_BUSYWAIT, 1'b1);
    @(negedge CLK);
    RESET = 1'b0;
    exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
    serve(1'b1, 1'b0, 32'h500, 32'h0, 32'h00000077, 5, 1'b0, 1'b1);

    // Both requesters held continuously: grant order depends on the starvation guard.
    begin
      int streak = 0;
      bit guard_on;
`ifdef ARB_STARVE_GUARD_EN
      guard_on = 1'b1;
`else
      guard_on = 1'b0;
`endif
      I_READ = 1'b1; I_ADDR = 32'h1000;
      D_READ = 1'b1; D_ADDR = 32'h2000; D_WRITEDATA = 32'h0;
      for (int g = 0; g < 6; g++) begin
        if (!(guard_on && streak == 2)) begin
          streak = (streak < 2) ? streak + 1 : 2;
          serve(1'b1, 1'b0, 32'h2000, 32'h0, $urandom, 0, 1'b0, 1'b0);
        end else begin
          streak = 0;
          serve(1'b0, 1'b0, 32'h1000, 32'h0, $urandom, 0, 1'b0, 1'b0);
        end
      end
      I_READ = 1'b0; D_READ = 1'b0;
      @(negedge CLK);
      chk1("drain_read", PORT_READ, 1'b0);
      chk1("drain_write", PORT_WRITE, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
